// File: rtl/katapayadi_pkg.sv
// Shared definitions for the katapayadi front-end and decoder side.
package katapayadi_pkg;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2
  } kfl_state_t;

  localparam int unsigned KP_MAX_FRAME = 15;

  function automatic logic kp_is_letter(input logic [7:0] b);
    return ((b >= 8'h41) && (b <= 8'h5A)) || ((b >= 8'h61) && (b <= 8'h7A));
  endfunction

endpackage

// File: rtl/katapayadi_frame_loader.sv
// Packs ASCII letters from a byte stream into a frame buffer and launches
// one hash job per frame, holding the buffer until done or watchdog expiry.
module katapayadi_frame_loader
  import katapayadi_pkg::*;
#(
  parameter int unsigned MAX_INPUT = 16,
  parameter int unsigned LEN_WIDTH = 4,
  parameter int unsigned TIMEOUT   = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             s_data,
  input  logic                   s_valid,
  input  logic                   s_last,
  output logic                   s_ready,
  output logic [8*MAX_INPUT-1:0] char_buf,
  output logic [LEN_WIDTH-1:0]   frame_len,
  output logic                   hash_start,
  input  logic                   hash_done,
  output logic                   busy,
  output logic                   frame_truncated,
  output logic                   timeout_err,
  output logic [15:0]            frame_count
);

  localparam int unsigned          WD_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [LEN_WIDTH-1:0] LEN_MAX = '1;
  localparam logic [WD_W-1:0]      WD_LAST = WD_W'(TIMEOUT - 1);

  kfl_state_t      state;
  logic [WD_W-1:0] wd;
  logic            take;

  assign s_ready = (state == FILL);
  assign busy    = (state != FILL);
  assign take    = s_valid && s_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= FILL;
      wd              <= '0;
      char_buf        <= '0;
      frame_len       <= '0;
      hash_start      <= 1'b0;
      frame_truncated <= 1'b0;
      timeout_err     <= 1'b0;
      frame_count     <= '0;
    end else begin
      hash_start <= 1'b0;
      case (state)
        FILL: begin
          if (take) begin
            if (kp_is_letter(s_data)) begin
              if (frame_len == LEN_MAX) begin
                frame_truncated <= 1'b1;
              end else begin
                char_buf[{frame_len, 3'b000} +: 8] <= s_data;
                frame_len                          <= frame_len + 1'b1;
              end
            end
            if (s_last) begin
              state      <= LAUNCH;
              hash_start <= 1'b1;
            end
          end
        end
        LAUNCH: begin
          state <= WAIT;
          wd    <= '0;
        end
        WAIT: begin
          wd <= wd + 1'b1;
          // done takes priority over a watchdog expiry in the same cycle
          if (hash_done || (wd == WD_LAST)) begin
            if (hash_done) frame_count <= frame_count + 1'b1;
            else           timeout_err <= 1'b1;
            state           <= FILL;
            char_buf        <= '0;
            frame_len       <= '0;
            frame_truncated <= 1'b0;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_katapayadi_frame_loader.sv
// Scoreboarded bench: frames are modelled from the letter-filter rules and
// the expected launch contents are checked by a monitor on hash_start.
module tb_katapayadi_frame_loader;

  localparam int unsigned MAX_INPUT = 16;
  localparam int unsigned LEN_WIDTH = 4;
  localparam int unsigned TIMEOUT   = 64;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    int                   len;
    logic [8*MAX_INPUT-1:0] buf_;
    logic                 trunc;
  } exp_t;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [7:0]             s_data;
  logic                   s_valid;
  logic                   s_last;
  logic                   s_ready;
  logic [8*MAX_INPUT-1:0] char_buf;
  logic [LEN_WIDTH-1:0]   frame_len;
  logic                   hash_start;
  logic                   hash_done;
  logic                   busy;
  logic                   frame_truncated;
  logic                   timeout_err;
  logic [15:0]            frame_count;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t exp_q[$];
  exp_t last_exp;
  int   exp_fc = 0;
  logic exp_to = 1'b0;

  katapayadi_frame_loader #(
    .MAX_INPUT(MAX_INPUT),
    .LEN_WIDTH(LEN_WIDTH),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .s_data         (s_data),
    .s_valid        (s_valid),
    .s_last         (s_last),
    .s_ready        (s_ready),
    .char_buf       (char_buf),
    .frame_len      (frame_len),
    .hash_start     (hash_start),
    .hash_done      (hash_done),
    .busy           (busy),
    .frame_truncated(frame_truncated),
    .timeout_err    (timeout_err),
    .frame_count    (frame_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic is_letter(input logic [7:0] b);
    return (b >= "A" && b <= "Z") || (b >= "a" && b <= "z");
  endfunction

  // Reference: keep letters, first 15 are stored, anything beyond marks truncation.
  function automatic exp_t model(input bq_t b);
    exp_t e;
    bq_t  letters;
    foreach (b[i]) if (is_letter(b[i])) letters.push_back(b[i]);
    e.len   = (letters.size() > 15) ? 15 : letters.size();
    e.trunc = (letters.size() > 15);
    e.buf_  = '0;
    for (int i = 0; i < e.len; i++) e.buf_[i*8 +: 8] = letters[i];
    return e;
  endfunction

  function automatic bq_t str2q(input string s);
    bq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  task automatic noise();
    s_valid = 1'($urandom_range(0, 1));
    s_data  = 8'($urandom);
    s_last  = 1'($urandom_range(0, 1));
  endtask

  // Called just after a clock edge with the DUT in FILL; returns just after
  // the edge that accepted the last byte.
  task automatic send_frame(input bq_t b, input bit gaps);
    int t;
    last_exp = model(b);
    exp_q.push_back(last_exp);
    for (int i = 0; i < b.size(); i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          s_valid = 1'b0;
          s_data  = 8'($urandom);
          s_last  = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
        end
      end
      s_valid = 1'b1;
      s_data  = b[i];
      s_last  = (i == b.size() - 1);
      t = 0;
      while (!s_ready && t < 100) begin
        @(posedge clk); #1;
        t++;
      end
      if (t == 100) chk("s_ready_wait_expired", 1, 0);
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // Starts in the LAUNCH cycle. d = WAIT cycle in which hash_done is raised.
  task automatic finish_job(input int d, input bit give_done);
    chk("launch_hash_start", hash_start, 1);
    chk("launch_s_ready", s_ready, 0);
    chk("launch_busy", busy, 1);
    noise();
    @(posedge clk); #1;
    chk("hash_start_width", hash_start, 0);
    if (give_done) begin
      repeat (d) begin noise(); @(posedge clk); #1; end
      chk("frozen_len", frame_len, last_exp.len);
      chk("frozen_buf", char_buf, last_exp.buf_);
      chk("frozen_trunc", frame_truncated, last_exp.trunc);
      chk("wait_s_ready", s_ready, 0);
      hash_done = 1'b1;
      @(posedge clk); #1;
      hash_done = 1'b0;
      s_valid   = 1'b0;
      exp_fc    = (exp_fc + 1) % 65536;
      chk("done_frame_count", frame_count, exp_fc);
    end else begin
      repeat (TIMEOUT - 1) begin noise(); @(posedge clk); #1; end
      chk("wd_last_busy", busy, 1);
      chk("wd_last_timeout_err", timeout_err, 0);
      @(posedge clk); #1;
      s_valid = 1'b0;
      exp_to  = 1'b1;
      chk("wd_frame_count", frame_count, exp_fc);
    end
    chk("retire_s_ready", s_ready, 1);
    chk("retire_busy", busy, 0);
    chk("retire_len", frame_len, 0);
    chk("retire_buf", char_buf, 0);
    chk("retire_trunc", frame_truncated, 0);
    chk("retire_timeout_err", timeout_err, exp_to);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_s_ready"}, s_ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_hash_start"}, hash_start, 0);
    chk({tag, "_len"}, frame_len, 0);
    chk({tag, "_buf"}, char_buf, 0);
    chk({tag, "_trunc"}, frame_truncated, 0);
    chk({tag, "_timeout_err"}, timeout_err, 0);
    chk({tag, "_frame_count"}, frame_count, 0);
  endtask

  // Monitor: every launch pulse must match the oldest outstanding frame.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && hash_start) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_launch", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("sb_len", frame_len, e.len);
          chk("sb_buf", char_buf, e.buf_);
          chk("sb_trunc", frame_truncated, e.trunc);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit: got timeout, expected completion");
    $fatal(1, "time limit");
  end

  initial begin
    bq_t b;
    rst_n     = 1'b0;
    s_data    = '0;
    s_valid   = 1'b0;
    s_last    = 1'b0;
    hash_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    send_frame(str2q("GOPI"), 1'b0);
    chk("gopi_len", frame_len, 4);
    chk("gopi_buf", char_buf[31:0], 32'h4950_4F47);
    finish_job(5, 1'b1);

    send_frame(str2q("m a-t!"), 1'b1);
    chk("filter_buf", char_buf[23:0], 24'h74_61_6D);
    finish_job(2, 1'b1);

    send_frame(str2q("ABCDEFGHIJKLMNOPQRST"), 1'b0);
    chk("ovf_last_byte", char_buf[119:112], 8'h4F);
    chk("ovf_trunc", frame_truncated, 1);
    finish_job(0, 1'b1);

    b = {8'h20};
    send_frame(b, 1'b0);
    chk("empty_len", frame_len, 0);
    finish_job(1, 1'b1);

    hash_done = 1'b1;
    @(posedge clk); #1;
    hash_done = 1'b0;
    chk("stray_done_count", frame_count, exp_fc);
    chk("stray_done_s_ready", s_ready, 1);

    for (int f = 0; f < 25; f++) begin
      b = {};
      repeat ($urandom_range(1, 24)) begin
        if ($urandom_range(0, 9) < 6)
          b.push_back(8'($urandom_range(0, 1) ? $urandom_range(65, 90) : $urandom_range(97, 122)));
        else
          b.push_back(8'($urandom));
      end
      send_frame(b, 1'b1);
      finish_job($urandom_range(0, 20), 1'b1);
    end

    send_frame(str2q("Edge"), 1'b0);
    finish_job(TIMEOUT - 1, 1'b1);

    send_frame(str2q("Stall"), 1'b0);
    finish_job(0, 1'b0);

    send_frame(str2q("Abort"), 1'b0);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_values("midjob_reset");
    exp_fc = 0;
    exp_to = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    send_frame(str2q("KA"), 1'b0);
    chk("ka_len", frame_len, 2);
    finish_job(3, 1'b1);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/katapayadi_frame_loader.md
# katapayadi_frame_loader

Upstream front-end for `katapayadi_hash` that turns a byte stream into hash jobs. It accepts a valid/ready byte stream and keeps only ASCII letters, packing them into a frame buffer of up to 15 characters. On end-of-frame it presents the buffer and length to the hash engine and pulses `hash_start`. It then holds the buffer stable until the engine reports `hash_done`, or until a watchdog expires.

## Interface
Parameters:
- `MAX_INPUT`, 16: buffer depth in characters; must match the hash engine.
- `LEN_WIDTH`, 4: width of `frame_len`. Maximum stored length is 2^LEN_WIDTH−1 = 15.
- `TIMEOUT`, 64: cycles to wait for `hash_done` before abandoning a job.

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  reset; asynchronous, active-low
- `s_data`  in  8  stream byte (ASCII)
- `s_valid`  in  1  byte valid
- `s_last`  in  1  byte is the final byte of the frame
- `s_ready`  out  1  loader accepts a byte this cycle
- `char_buf`  out  8*MAX_INPUT  flattened buffer; char i occupies bits [8i+7:8i]
- `frame_len`  out  LEN_WIDTH  number of stored characters
- `hash_start`  out  1  one-cycle launch pulse to the engine
- `hash_done`  in  1  engine completion pulse
- `busy`  out  1  a job is launched and not yet retired
- `frame_truncated`  out  1  current or last frame exceeded 15 letters
- `timeout_err`  out  1  sticky; the watchdog has fired
- `frame_count`  out  16  jobs retired via `hash_done`; wraps modulo 2^16

## Operation
- States are FILL, LAUNCH and WAIT. Reset state is FILL.
- `s_ready` = (state == FILL), driven combinationally. It reads 1 during reset.
- **Accept rule:** a byte is accepted when `s_valid && s_ready`.
  - A byte is stored only if it is in 0x41–0x5A or 0x61–0x7A. All other bytes are dropped.
  - A stored byte goes to `char_buf[frame_len]`, and `frame_len` increments.
- **Overflow:** when `frame_len` == 15, further letters are dropped and `frame_truncated` is set. Stored data never changes after that point in the frame.
- **End of frame:** an accepted byte with `s_last`=1 is filtered and stored like any other byte. The state then moves FILL→LAUNCH.
- **LAUNCH:** `hash_start`=1 for exactly this cycle. The next state is WAIT and the watchdog counter clears.
- **WAIT:**
  - `char_buf` and `frame_len` are frozen.
  - The watchdog increments each cycle.
  - On `hash_done`=1: `frame_count` increments, then go to FILL.
  - When the watchdog reaches TIMEOUT−1 without `hash_done`: set `timeout_err`, then go to FILL.
  - If `hash_done` arrives in that same cycle, done wins: the job counts and `timeout_err` is not set.
- **Entering FILL from WAIT:** `char_buf` is zeroed, `frame_len` is set to 0 and `frame_truncated` clears.
- **Empty frame:** a frame with no letters still launches, with `frame_len`=0.
- **Stray input:** `hash_done` seen in FILL or LAUNCH is ignored.
- `busy` = (state != FILL).

## Timing
- Reset values:
  - `s_ready`=1.
  - `char_buf`, `frame_len`, `hash_start`, `busy`, `frame_truncated`, `timeout_err` and `frame_count` all 0.
- Last byte accepted at edge k:
  - State is LAUNCH in cycle k+1: `hash_start`=1, `s_ready`=0, `busy`=1.
  - State is WAIT from cycle k+2.
- `hash_done` high in cycle m: `s_ready`=1 and the buffer reads cleared in cycle m+1.
- Minimum spacing between launches is 3 cycles.
- Reset asserted mid-job: every output returns to its reset value at once. Any in-flight engine job is abandoned.

## Structure
- Shared package `katapayadi_pkg` holds:
  - the state enum `kfl_state_t`;
  - the constant `KP_MAX_FRAME` = 15;
  - the function `kp_is_letter(byte)`, shared with the decoder side.
- Single module, no sub-modules. The watchdog is an inline counter of $clog2(TIMEOUT) bits.

## Test plan
- **Basic frame:** stream "GOPI" with `s_last` on 'I'.
  - `frame_len`=4 and `char_buf[31:0]`=0x4950_4F47.
  - `hash_start` is high for exactly one cycle, one cycle after the last byte.
  - `s_ready` is 0 until `hash_done`, then `frame_count`=1.
- **Filtering:** stream "m a-t!" then last → `frame_len`=3, stored "mat" (0x74_61_6D), `frame_truncated`=0.
- **Overflow:** stream 20 letters "ABCDEFGHIJKLMNOPQRST" → `frame_len`=15, last stored byte 'O' (0x4F), `frame_truncated`=1.
- **Empty frame:** stream a single 0x20 with last → `hash_start` pulses with `frame_len`=0; after done, back in FILL.
- **Watchdog:**
  - Launch a frame and hold `hash_done` low → after TIMEOUT cycles `timeout_err`=1, `s_ready`=1, `frame_count` unchanged.
  - Repeat with `hash_done` coinciding with the final watchdog cycle → `frame_count` increments and `timeout_err` stays 0.
- **Reset mid-job:** assert `rst_n`=0 in WAIT → all outputs at reset values immediately. A following frame "KA" launches normally with `frame_len`=2.
